// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: IO address map and program-stop FSM encodings
package mem_io_responder_pkg;
    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [17:0] IO_UART   = 18'h00000;
    localparam logic [17:0] IO_CLK    = 18'h00004;
    localparam logic [17:0] IO_UART_A = IO_BASE + IO_UART;
    localparam logic [17:0] IO_CLK_A  = IO_BASE + IO_CLK;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte-wide FIFO with wrap-bit pointers and combinational head
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        pop,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];
    // A push into a full FIFO is legal when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus responder with RAM, UART FIFOs, cycle counter and stop sequencing
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_done,
    output logic        tx_overflow
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam logic [TCW-1:0] FULL_TH = TCW'(TX_DEPTH - FULL_MARGIN - 1);

    logic [7:0]  ram [2**ADDR_W];
    logic [17:0] a;
    logic        unused_hi;
    logic        io_sel, rd, wr, run, uart_wr, stop_wr, tx_req, clk_rd;
    logic        tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_din, rx_dout, io_rdata;
    logic [TCW-1:0] tx_count, tx_count_d;
    logic [RCW-1:0] rx_count;
    logic [7:0]  mem_din_q, mem_din_d;
    logic [31:0] cnt_q, cnt_d, snap_q, snap_d;
    logic        ovf_q, ovf_d, full_q, full_d;
    state_e      state_q, state_d;

    assign a         = mem_a[17:0];
    assign unused_hi = ^{mem_a[31:18], rx_count};
    assign io_sel    = a[17:16] == 2'b11;
    assign rd        = rdy_in && !mem_wr;
    assign wr        = rdy_in && mem_wr;
    assign run       = state_q == ST_RUN;
    assign clk_rd    = rd && a == IO_CLK_A;
    assign uart_wr   = wr && run && a == IO_UART_A && mem_dout != 8'h00;
    assign stop_wr   = wr && run && a == IO_CLK_A;
    assign tx_req    = uart_wr || stop_wr;
    assign tx_din    = stop_wr ? 8'h00 : mem_dout;
    assign tx_pop    = tx_ready && !tx_empty;
    assign tx_push   = tx_req && (!tx_full || tx_pop);
    assign rx_push   = rx_valid && !rx_full;
    assign rx_pop    = rd && a == IO_UART_A && !rx_empty;

    assign io_rdata = a == IO_UART_A          ? (rx_empty ? 8'h00 : rx_dout) :
                      a == IO_CLK_A           ? cnt_q[7:0]   :
                      a == IO_CLK_A + 18'd1   ? snap_q[15:8]  :
                      a == IO_CLK_A + 18'd2   ? snap_q[23:16] :
                      a == IO_CLK_A + 18'd3   ? snap_q[31:24] : 8'h00;

    always_comb begin
        mem_din_d  = rd ? (io_sel ? io_rdata : ram[a[ADDR_W-1:0]]) : mem_din_q;
        cnt_d      = (rdy_in && run) ? cnt_q + 32'd1 : cnt_q;
        snap_d     = clk_rd ? cnt_q : snap_q;
        ovf_d      = ovf_q || (tx_req && !tx_push);
        tx_count_d = tx_count + TCW'(tx_push) - TCW'(tx_pop);
        full_d     = tx_count_d > FULL_TH;
        state_d    = stop_wr                                ? ST_DRAIN :
                     (state_q == ST_DRAIN && tx_empty)      ? ST_DONE  : state_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= 8'h00;
            cnt_q     <= '0;
            snap_q    <= '0;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            mem_din_q <= mem_din_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            state_q   <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr && !io_sel) ram[a[ADDR_W-1:0]] <= mem_dout;
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk(clk_in), .rst_n(rst_in), .push(tx_push), .din(tx_din), .pop(tx_pop),
        .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk(clk_in), .rst_n(rst_in), .push(rx_push), .din(rx_data), .pop(rx_pop),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign mem_din        = mem_din_q;
    assign io_buffer_full = full_q;
    assign tx_valid       = !tx_empty;
    assign rx_ready       = !rx_full;
    assign prog_done      = state_q == ST_DONE;
    assign tx_overflow    = ovf_q;
endmodule
